// File: rtl/can_pkg.sv
// Shared CAN receive-path types and constants.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DYNAMIC = 2'd1,
    FIXED   = 2'd2,
    ERROR   = 2'd3
  } state_e;

  localparam int unsigned STUFF_LEN_DEF    = 5;
  localparam int unsigned FIXED_PERIOD_DEF = 4;
  localparam logic        REC_LEVEL        = 1'b1;

endpackage

// File: rtl/bit_destuffer.sv
// Removes CAN/CAN-FD stuff bits on each sample-point strobe, flags stuff errors
// and counts dynamic stuff bits for the FD CRC field.
module bit_destuffer
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = STUFF_LEN_DEF,
  parameter int unsigned FIXED_PERIOD = FIXED_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       samplePoint,
  input  logic       canRX,
  input  logic       isStart,
  input  logic       BS_onoff,
  input  logic       fixedMode,
  output logic       bitOut,
  output logic       bitValid,
  output logic       isStuff,
  output logic       isError,
  output logic [2:0] stuffCount
);

  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned FIX_W = $clog2(FIXED_PERIOD + 1);

  state_e           state, state_nxt;
  logic             last_bit, last_nxt;
  logic [RUN_W-1:0] run_len, run_nxt;
  logic [FIX_W-1:0] fix_cnt, fix_nxt;
  logic [2:0]       cnt_nxt;
  logic             out_nxt, valid_nxt, stuff_nxt, err_nxt;
  logic             fixed_stuff_c;

  // A fixed stuff bit is due on entry to the CRC field and after every FIXED_PERIOD data bits.
  assign fixed_stuff_c = (state == DYNAMIC && fixedMode) ||
                         (state == FIXED && fix_cnt == FIX_W'(FIXED_PERIOD));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_bit   <= REC_LEVEL;
      run_len    <= '0;
      fix_cnt    <= '0;
      stuffCount <= '0;
      bitOut     <= REC_LEVEL;
      bitValid   <= 1'b0;
      isStuff    <= 1'b0;
      isError    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_bit   <= last_nxt;
      run_len    <= run_nxt;
      fix_cnt    <= fix_nxt;
      stuffCount <= cnt_nxt;
      bitOut     <= out_nxt;
      bitValid   <= valid_nxt;
      isStuff    <= stuff_nxt;
      isError    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_bit;
    run_nxt   = run_len;
    fix_nxt   = fix_cnt;
    cnt_nxt   = stuffCount;
    out_nxt   = bitOut;
    valid_nxt = 1'b0;
    stuff_nxt = 1'b0;
    err_nxt   = isError;
    if (samplePoint) begin
      if (isStart) begin
        state_nxt = DYNAMIC;
        last_nxt  = canRX;
        run_nxt   = RUN_W'(1);
        fix_nxt   = '0;
        cnt_nxt   = '0;
        err_nxt   = 1'b0;
        out_nxt   = canRX;
        valid_nxt = 1'b1;
      end else if (state == ERROR) begin
        err_nxt = 1'b1;
      end else if (!BS_onoff || state == IDLE) begin
        // Outside the stuffed region bits pass through unchecked.
        state_nxt = IDLE;
        out_nxt   = canRX;
        valid_nxt = 1'b1;
      end else if (fixed_stuff_c) begin
        out_nxt  = canRX;
        last_nxt = canRX;
        fix_nxt  = '0;
        if (canRX != last_bit) begin
          state_nxt = FIXED;
          stuff_nxt = 1'b1;
        end else begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end
      end else if (state == FIXED) begin
        out_nxt   = canRX;
        valid_nxt = 1'b1;
        last_nxt  = canRX;
        fix_nxt   = fix_cnt + 1'b1;
      end else if (run_len == RUN_W'(STUFF_LEN)) begin
        if (canRX != last_bit) begin
          out_nxt   = canRX;
          stuff_nxt = 1'b1;
          run_nxt   = RUN_W'(1);
          last_nxt  = canRX;
          cnt_nxt   = stuffCount + 1'b1;
        end else begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end
      end else begin
        out_nxt   = canRX;
        valid_nxt = 1'b1;
        if (canRX == last_bit) begin
          run_nxt = run_len + 1'b1;
        end else begin
          run_nxt  = RUN_W'(1);
          last_nxt = canRX;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_destuffer.sv
// Directed bench for bit_destuffer: expectations queued per strobe, checked one clk later.
module tb_bit_destuffer;

  typedef struct {
    logic       valid;
    logic       stuff;
    logic       err;
    logic [2:0] cnt;
    logic       bo;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       samplePoint;
  logic       canRX;
  logic       isStart;
  logic       BS_onoff;
  logic       fixedMode;
  logic       bitOut;
  logic       bitValid;
  logic       isStuff;
  logic       isError;
  logic [2:0] stuffCount;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  bit_destuffer dut (
    .clk        (clk),
    .reset      (reset),
    .samplePoint(samplePoint),
    .canRX      (canRX),
    .isStart    (isStart),
    .BS_onoff   (BS_onoff),
    .fixedMode  (fixedMode),
    .bitOut     (bitOut),
    .bitValid   (bitValid),
    .isStuff    (isStuff),
    .isError    (isError),
    .stuffCount (stuffCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe: queue the expectation, clock, compare, then an idle clock with no pulses.
  task automatic strobe(input logic rx, input logic st, input logic ev, input logic es,
                        input logic ee, input logic [2:0] ec, input string tag);
    exp_t e;
    e.valid = ev; e.stuff = es; e.err = ee; e.cnt = ec; e.bo = rx; e.tag = tag;
    q.push_back(e);
    samplePoint = 1'b1;
    canRX       = rx;
    isStart     = st;
    @(posedge clk);
    #1;
    samplePoint = 1'b0;
    isStart     = 1'b0;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".valid"}, 3'(bitValid), 3'(e.valid));
      chk({e.tag, ".stuff"}, 3'(isStuff), 3'(e.stuff));
      chk({e.tag, ".err"}, 3'(isError), 3'(e.err));
      chk({e.tag, ".cnt"}, stuffCount, e.cnt);
      if (e.valid) chk({e.tag, ".bitout"}, 3'(bitOut), 3'(e.bo));
    end
    @(posedge clk);
    #1;
    chk({tag, ".idle_valid"}, 3'(bitValid), 3'd0);
    chk({tag, ".idle_stuff"}, 3'(isStuff), 3'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".bitout"}, 3'(bitOut), 3'd1);
    chk({tag, ".valid"}, 3'(bitValid), 3'd0);
    chk({tag, ".stuff"}, 3'(isStuff), 3'd0);
    chk({tag, ".err"}, 3'(isError), 3'd0);
    chk({tag, ".cnt"}, stuffCount, 3'd0);
  endtask

  initial begin
    logic b;
    reset = 1'b1; samplePoint = 1'b0; canRX = 1'b1; isStart = 1'b0;
    BS_onoff = 1'b1; fixedMode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    reset = 1'b0;

    // Stuff bit after five dominant bits
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t1_sof");
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t1_run");
    strobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, "t1_stuff");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, "t1_next");

    // Six equal bits give a stuff error that stays until isStart
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t2_sof");
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t2_run");
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, "t2_err");
    strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, "t2_hold");
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, "t2_hold2");

    // Restart clears the error; eight stuff bits wrap the count
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t3_sof");
    b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      for (int k = 0; k < 4; k++) strobe(b, 1'b0, 1'b1, 1'b0, 1'b0, 3'((i - 1) % 8), "t3_data");
      b = ~b;
      strobe(b, 1'b0, 1'b0, 1'b1, 1'b0, 3'(i % 8), "t3_stuff");
    end

    // Fixed stuffing in the FD CRC field, good final stuff bit
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t4_sof");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t4_last0");
    fixedMode = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "t4_fs0");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t4_d0");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t4_d1");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t4_d2");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t4_d3");
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "t4_fs1");
    fixedMode = 1'b0;

    // Same sequence with a bad final fixed stuff bit
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t5_sof");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t5_last0");
    fixedMode = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "t5_fs0");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t5_d0");
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t5_d1");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t5_d2");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t5_d3");
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, "t5_fs_bad");
    fixedMode = 1'b0;

    // Stuffing off: seven recessive bits pass through unchecked
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t6_sof");
    BS_onoff = 1'b0;
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t6_pass");
    BS_onoff = 1'b1;

    // Reset mid-run, then no stuff checking until the next isStart
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t7_sof");
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t7_run");
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("t7_reset");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t7_post");
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "t7_sof2");
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t7_run2");
    strobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, "t7_stuff");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
